// File: rtl/hdmi_pkg.sv
// Shared encodings and phase lengths for the HDMI data-island scheduler.
package hdmi_pkg;

    typedef enum logic [2:0] {
        PKT_NULL         = 3'd0,
        PKT_AVI          = 3'd1,
        PKT_AUDIO_IF     = 3'd2,
        PKT_ACR          = 3'd3,
        PKT_AUDIO_SAMPLE = 3'd4
    } pkt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_LEAD,
        ST_PKT,
        ST_TRAIL
    } island_state_t;

    localparam int unsigned PREAMBLE_LEN = 8;
    localparam int unsigned GUARD_LEN    = 2;
    localparam int unsigned PACKET_LEN   = 32;
    localparam int unsigned ISLAND_LEN   = PREAMBLE_LEN + 2 * GUARD_LEN + PACKET_LEN;

    localparam logic [3:0] CTL_ISLAND_PREAMBLE = 4'b0101;
    localparam logic [3:0] CTL_VIDEO_PREAMBLE  = 4'b0001;

    function automatic logic [5:0] last_phase(input int unsigned len);
        return 6'(len - 1);
    endfunction

endpackage

// File: rtl/hdmi_audio_credit.sv
// Audio sample credit accumulator and channel-status packet index.
module hdmi_audio_credit
    import hdmi_pkg::*;
#(
    parameter int unsigned CREDIT_ADD      = 1600,
    parameter int unsigned SAMPLES_PER_PKT = 12,
    parameter int unsigned CREDIT_W        = 25,
    parameter int unsigned CS_FRAMES       = 48
) (
    input  logic                pixclk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                award,
    output logic [CREDIT_W-1:0] audio_credit,
    output logic [5:0]          cs_index,
    output logic                cs_first
);

    localparam int unsigned SUM_W = CREDIT_W + 2;

    logic [SUM_W-1:0] sum;

    // Two spare bits: the top one flags underflow, the next one overflow.
    always_comb begin
        sum = {2'b00, audio_credit};
        if (frame_tick) sum = sum + SUM_W'(CREDIT_ADD);
        if (award)      sum = sum - SUM_W'(SAMPLES_PER_PKT);
    end

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            audio_credit <= '0;
            cs_index     <= '0;
            cs_first     <= 1'b0;
        end else begin
            if (sum[SUM_W-1])      audio_credit <= '0;
            else if (sum[SUM_W-2]) audio_credit <= '1;
            else                   audio_credit <= sum[CREDIT_W-1:0];

            if (award) begin
                cs_first <= (cs_index == '0);
                cs_index <= (cs_index == 6'(CS_FRAMES - 1)) ? '0 : cs_index + 6'd1;
            end
        end
    end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// Per-line data-island / video preamble sequencer with packet arbitration.
module hdmi_island_scheduler
    import hdmi_pkg::*;
#(
    parameter int unsigned DATA_START      = 664,
    parameter int unsigned CTL_END         = 758,
    parameter int unsigned ISLAND_LINES    = 136,
    parameter int unsigned CREDIT_ADD      = 1600,
    parameter int unsigned SAMPLES_PER_PKT = 12,
    parameter int unsigned CREDIT_W        = 25,
    parameter int unsigned CS_FRAMES       = 48
) (
    input  logic                pixclk,
    input  logic                reset,
    input  logic [9:0]          counter_x,
    input  logic [9:0]          counter_y,
    input  logic                frame_tick,
    input  logic [2:0]          req,
    output logic [2:0]          grant,
    output logic [2:0]          pkt_sel,
    output logic                pkt_load,
    output logic                island_preamble,
    output logic                island_guard,
    output logic                island_active,
    output logic [4:0]          data_offset,
    output logic                video_preamble,
    output logic                video_guard,
    output logic                cs_first,
    output logic [5:0]          cs_index,
    output logic [CREDIT_W-1:0] audio_credit
);

    if (DATA_START + ISLAND_LEN > CTL_END) begin : g_bad_timing
        $error("data island would overlap the video preamble");
    end

    island_state_t state;
    logic [5:0]    phase;
    pkt_t          arb_sel;
    logic [2:0]    arb_grant;
    logic          island_start;
    logic          arb_edge;
    logic          credit_ok;
    logic          award;

    assign island_start = (state == ST_IDLE) && (counter_x == 10'(DATA_START))
                          && (counter_y < 10'(ISLAND_LINES));
    assign arb_edge     = (state == ST_PRE) && (phase == last_phase(PREAMBLE_LEN));
    assign credit_ok    = audio_credit >= CREDIT_W'(SAMPLES_PER_PKT);
    assign award        = arb_edge && (arb_sel == PKT_AUDIO_SAMPLE);

    always_comb begin
        arb_grant = '0;
        arb_sel   = PKT_NULL;
        if (req[2]) begin
            arb_grant = 3'b100;
            arb_sel   = PKT_ACR;
        end else if (req[0]) begin
            arb_grant = 3'b001;
            arb_sel   = PKT_AVI;
        end else if (req[1]) begin
            arb_grant = 3'b010;
            arb_sel   = PKT_AUDIO_IF;
        end else if (credit_ok) begin
            arb_sel   = PKT_AUDIO_SAMPLE;
        end
    end

    hdmi_audio_credit #(
        .CREDIT_ADD      (CREDIT_ADD),
        .SAMPLES_PER_PKT (SAMPLES_PER_PKT),
        .CREDIT_W        (CREDIT_W),
        .CS_FRAMES       (CS_FRAMES)
    ) u_credit (
        .pixclk       (pixclk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .award        (award),
        .audio_credit (audio_credit),
        .cs_index     (cs_index),
        .cs_first     (cs_first)
    );

    // Outputs are assigned on the transition edge so they describe the state being entered.
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            phase           <= '0;
            grant           <= '0;
            pkt_sel         <= '0;
            pkt_load        <= 1'b0;
            island_preamble <= 1'b0;
            island_guard    <= 1'b0;
            island_active   <= 1'b0;
            data_offset     <= '0;
            video_preamble  <= 1'b0;
            video_guard     <= 1'b0;
        end else begin
            grant          <= '0;
            pkt_load       <= 1'b0;
            video_preamble <= (counter_x >= 10'(CTL_END))
                              && (counter_x <= 10'(CTL_END + PREAMBLE_LEN - 1));
            video_guard    <= (counter_x >= 10'(CTL_END + PREAMBLE_LEN))
                              && (counter_x <= 10'(CTL_END + PREAMBLE_LEN + GUARD_LEN - 1));

            case (state)
                ST_IDLE: begin
                    if (island_start) begin
                        state           <= ST_PRE;
                        phase           <= '0;
                        island_preamble <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (arb_edge) begin
                        state           <= ST_LEAD;
                        phase           <= '0;
                        island_preamble <= 1'b0;
                        island_guard    <= 1'b1;
                        island_active   <= 1'b1;
                        grant           <= arb_grant;
                        pkt_sel         <= arb_sel;
                    end else begin
                        phase <= phase + 6'd1;
                    end
                end
                ST_LEAD: begin
                    if (phase == last_phase(GUARD_LEN)) begin
                        state        <= ST_PKT;
                        phase        <= '0;
                        island_guard <= 1'b0;
                        data_offset  <= '0;
                    end else begin
                        phase    <= phase + 6'd1;
                        pkt_load <= (phase + 6'd1 == last_phase(GUARD_LEN));
                    end
                end
                ST_PKT: begin
                    if (phase == last_phase(PACKET_LEN)) begin
                        state        <= ST_TRAIL;
                        phase        <= '0;
                        island_guard <= 1'b1;
                        data_offset  <= '0;
                    end else begin
                        phase       <= phase + 6'd1;
                        data_offset <= 5'(phase + 6'd1);
                    end
                end
                ST_TRAIL: begin
                    if (phase == last_phase(GUARD_LEN)) begin
                        state         <= ST_IDLE;
                        phase         <= '0;
                        island_guard  <= 1'b0;
                        island_active <= 1'b0;
                    end else begin
                        phase <= phase + 6'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    phase <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Bench for hdmi_island_scheduler: scripted and random lines against an offset-based reference model.
module tb_hdmi_island_scheduler;

    localparam int DATA_START      = 664;
    localparam int CTL_END         = 758;
    localparam int ISLAND_LINES    = 136;
    localparam int CREDIT_ADD      = 1600;
    localparam int SAMPLES_PER_PKT = 12;
    localparam int CREDIT_W        = 25;
    localparam int CS_FRAMES       = 48;
    localparam int CREDIT_MAX      = (1 << CREDIT_W) - 1;

    logic                pixclk = 1'b0;
    logic                reset;
    logic [9:0]          counter_x;
    logic [9:0]          counter_y;
    logic                frame_tick;
    logic [2:0]          req;
    logic [2:0]          grant;
    logic [2:0]          pkt_sel;
    logic                pkt_load;
    logic                island_preamble;
    logic                island_guard;
    logic                island_active;
    logic [4:0]          data_offset;
    logic                video_preamble;
    logic                video_guard;
    logic                cs_first;
    logic [5:0]          cs_index;
    logic [CREDIT_W-1:0] audio_credit;

    hdmi_island_scheduler #(
        .DATA_START      (DATA_START),
        .CTL_END         (CTL_END),
        .ISLAND_LINES    (ISLAND_LINES),
        .CREDIT_ADD      (CREDIT_ADD),
        .SAMPLES_PER_PKT (SAMPLES_PER_PKT),
        .CREDIT_W        (CREDIT_W),
        .CS_FRAMES       (CS_FRAMES)
    ) dut (
        .pixclk          (pixclk),
        .reset           (reset),
        .counter_x       (counter_x),
        .counter_y       (counter_y),
        .frame_tick      (frame_tick),
        .req             (req),
        .grant           (grant),
        .pkt_sel         (pkt_sel),
        .pkt_load        (pkt_load),
        .island_preamble (island_preamble),
        .island_guard    (island_guard),
        .island_active   (island_active),
        .data_offset     (data_offset),
        .video_preamble  (video_preamble),
        .video_guard     (video_guard),
        .cs_first        (cs_first),
        .cs_index        (cs_index),
        .audio_credit    (audio_credit)
    );

    always #5 pixclk = ~pixclk;

    int unsigned n_checks;
    int unsigned n_fail;

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference model: island position is just "edges since the start edge".
    int          cyc;
    int          m_start;
    bit          m_started;
    int unsigned m_credit;
    int unsigned m_sel;
    int unsigned m_grant;
    int unsigned m_awards;
    int unsigned m_csfirst;
    int unsigned e_pre, e_guard, e_active, e_off, e_load, e_vpre, e_vguard;

    task automatic model_reset();
        m_started = 1'b0;
        m_start   = 0;
        m_credit  = 0;
        m_sel     = 0;
        m_grant   = 0;
        m_awards  = 0;
        m_csfirst = 0;
        e_pre     = 0;
        e_guard   = 0;
        e_active  = 0;
        e_off     = 0;
        e_load    = 0;
        e_vpre    = 0;
        e_vguard  = 0;
    endtask

    task automatic model_edge();
        int k;
        bit busy;
        bit award;
        int x;
        cyc++;
        x     = int'(counter_x);
        busy  = m_started && ((cyc - m_start) <= 44);
        if (!busy && x == DATA_START && int'(counter_y) < ISLAND_LINES) begin
            m_started = 1'b1;
            m_start   = cyc;
        end
        k       = m_started ? (cyc - m_start) : 1000;
        m_grant = 0;
        award   = 1'b0;
        if (k == 8) begin
            if (req[2])                           begin m_grant = 4; m_sel = 3; end
            else if (req[0])                      begin m_grant = 1; m_sel = 1; end
            else if (req[1])                      begin m_grant = 2; m_sel = 2; end
            else if (m_credit >= SAMPLES_PER_PKT) begin m_sel = 4; award = 1'b1; end
            else                                  m_sel = 0;
        end
        if (frame_tick)
            m_credit = (m_credit + CREDIT_ADD > CREDIT_MAX) ? CREDIT_MAX : m_credit + CREDIT_ADD;
        if (award) begin
            m_credit  = m_credit - SAMPLES_PER_PKT;
            m_csfirst = ((m_awards % CS_FRAMES) == 0) ? 1 : 0;
            m_awards++;
        end
        e_pre    = (k < 8) ? 1 : 0;
        e_guard  = ((k >= 8 && k < 10) || (k >= 42 && k < 44)) ? 1 : 0;
        e_active = (k >= 8 && k < 44) ? 1 : 0;
        e_off    = (k >= 10 && k < 42) ? k - 10 : 0;
        e_load   = (k == 9) ? 1 : 0;
        e_vpre   = (x >= CTL_END && x <= CTL_END + 7) ? 1 : 0;
        e_vguard = (x >= CTL_END + 8 && x <= CTL_END + 9) ? 1 : 0;
    endtask

    task automatic check_outputs();
        check_eq("grant",           32'(grant),           m_grant);
        check_eq("pkt_sel",         32'(pkt_sel),         m_sel);
        check_eq("pkt_load",        32'(pkt_load),        e_load);
        check_eq("island_preamble", 32'(island_preamble), e_pre);
        check_eq("island_guard",    32'(island_guard),    e_guard);
        check_eq("island_active",   32'(island_active),   e_active);
        check_eq("data_offset",     32'(data_offset),     e_off);
        check_eq("video_preamble",  32'(video_preamble),  e_vpre);
        check_eq("video_guard",     32'(video_guard),     e_vguard);
        check_eq("cs_first",        32'(cs_first),        m_csfirst);
        check_eq("cs_index",        32'(cs_index),        m_awards % CS_FRAMES);
        check_eq("audio_credit",    32'(audio_credit),    m_credit);
    endtask

    task automatic tick();
        @(posedge pixclk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        check_outputs();
    endtask

    // One scan line: x sweeps the island window, then skips to the video preamble window.
    task automatic run_line(input int y, input logic [2:0] r, input int tick_x,
                            input int abort_k, input bit reload);
        int x;
        x         = DATA_START - 2;
        counter_y = 10'(y);
        req       = r;
        while (x <= CTL_END + 11) begin
            counter_x  = 10'(x);
            frame_tick = (x == tick_x);
            tick();
            if (abort_k >= 0 && m_started && (cyc - m_start) == abort_k) begin
                check_eq("abort_offset", 32'(data_offset), 32'(abort_k - 10));
                reset      = 1'b1;
                frame_tick = 1'b0;
                #1;
                model_reset();
                check_outputs();
                tick();
                reset = 1'b0;
            end
            if (x == DATA_START + 45 || (reload && x == 30)) x = CTL_END - 2;
            else if (reload && x == DATA_START + 20)         x = 0;
            else                                             x++;
        end
        frame_tick = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        model_reset();
        reset      = 1'b1;
        counter_x  = '0;
        counter_y  = '0;
        frame_tick = 1'b0;
        req        = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        run_line(0, 3'b101, -1, -1, 1'b0);
        run_line(1, 3'b001, -1, -1, 1'b0);
        run_line(2, 3'b010, -1, 20, 1'b0);

        for (int y = 3; y <= 137; y++)
            run_line(y, 3'b000, (y == 3) ? DATA_START - 2 : -1, -1, 1'b0);
        check_eq("credit_frame1", 32'(audio_credit), 32'(CREDIT_ADD - 133 * SAMPLES_PER_PKT));
        check_eq("cs_index_frame1", 32'(cs_index), 32'(133 % CS_FRAMES));

        for (int y = 0; y <= 135; y++)
            run_line(y, 3'b000, (y == 0) ? DATA_START - 2 : -1, -1, 1'b0);
        check_eq("credit_frame2", 32'(audio_credit), 32'd8);

        for (int y = 0; y <= 132; y++)
            run_line(y, 3'b000, (y == 0) ? DATA_START - 2 : -1, -1, 1'b0);
        check_eq("credit_frame3", 32'(audio_credit), 32'd12);
        run_line(133, 3'b000, DATA_START + 8, -1, 1'b0);
        check_eq("credit_tick_and_award", 32'(audio_credit), 32'(CREDIT_ADD));

        run_line(5, 3'b010, -1, -1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            int y;
            int tx;
            y  = int'($urandom_range(0, 139));
            tx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DATA_START - 2, DATA_START + 45)) : -1;
            run_line(y, 3'($urandom_range(0, 7)), tx, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
